// File: rtl/pico_mips_pkg.sv
// pico_mips_pkg: shared width, default affine coefficients and FSM states for pico_mips.
package pico_mips_pkg;
  localparam int W = 8;
  localparam logic signed [W-1:0] DEF_A11 = 8'sd96;
  localparam logic signed [W-1:0] DEF_A12 = 8'sd64;
  localparam logic signed [W-1:0] DEF_A21 = -8'sd64;
  localparam logic signed [W-1:0] DEF_A22 = 8'sd96;
  localparam logic signed [W-1:0] DEF_B1 = 8'sd20;
  localparam logic signed [W-1:0] DEF_B2 = -8'sd20;
  typedef enum logic [3:0] {
    WAIT_X_HI, WAIT_X_LO, WAIT_Y_HI, WAIT_Y_LO, C1, C2, C3, C4, SHOW_X, SHOW_Y
  } state_t;
endpackage

// File: rtl/pico_mips_mac.sv
// pico_mips_mac: Q1.7 multiply, floor-scaled back to 8 bits, plus a wrapping addend.
module pico_mips_mac
  import pico_mips_pkg::*;
(
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  output logic signed [W-1:0] y
);
  logic signed [2*W-1:0] p;
  assign p = a * b;
  assign y = p[2*W-2:W-1] + c;
endmodule

// File: rtl/pico_mips.sv
// pico_mips: switch-handshake affine transform engine driving the LEDs.
// PICOMIPS_SYNC_EN adds a 2-flop handshake synchronizer and a data register.
module pico_mips
  import pico_mips_pkg::*;
#(
  parameter logic signed [W-1:0] A11 = DEF_A11,
  parameter logic signed [W-1:0] A12 = DEF_A12,
  parameter logic signed [W-1:0] A21 = DEF_A21,
  parameter logic signed [W-1:0] A22 = DEF_A22,
  parameter logic signed [W-1:0] B1 = DEF_B1,
  parameter logic signed [W-1:0] B2 = DEF_B2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   SW,
  output logic [W-1:0] LED
);
  state_t state, state_n;
  logic signed [W-1:0] x1, y1, x2, y2, acc, ma, mb, mc, mo;
  logic hs;
  logic [W-1:0] d;
  logic unused_sw;
  assign unused_sw = SW[9];
`ifdef PICOMIPS_SYNC_EN
  logic [1:0] hs_q;
  logic [W-1:0] d_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= '0;
      d_q <= '0;
    end else begin
      hs_q <= {hs_q[0], SW[8]};
      d_q <= SW[W-1:0];
    end
  end
  assign hs = hs_q[1];
  assign d = d_q;
`else
  assign hs = SW[8];
  assign d = SW[W-1:0];
`endif
  assign ma = (state == C1) ? A11 : (state == C2) ? A12 : (state == C3) ? A21 : A22;
  assign mb = (state == C1 || state == C3) ? x1 : y1;
  assign mc = (state == C1) ? B1 : (state == C3) ? B2 : acc;
  pico_mips_mac mac (.a(ma), .b(mb), .c(mc), .y(mo));
  always_comb begin
    state_n = state;
    case (state)
      WAIT_X_HI: state_n = hs ? WAIT_X_LO : state;
      WAIT_X_LO: state_n = hs ? state : WAIT_Y_HI;
      WAIT_Y_HI: state_n = hs ? WAIT_Y_LO : state;
      WAIT_Y_LO: state_n = hs ? state : C1;
      C1: state_n = C2;
      C2: state_n = C3;
      C3: state_n = C4;
      C4: state_n = SHOW_X;
      SHOW_X: state_n = hs ? SHOW_Y : state;
      SHOW_Y: state_n = hs ? state : WAIT_X_HI;
      default: state_n = WAIT_X_HI;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_X_HI;
      x1 <= '0;
      y1 <= '0;
      x2 <= '0;
      y2 <= '0;
      acc <= '0;
      LED <= '0;
    end else begin
      state <= state_n;
      if (state == WAIT_X_HI && hs) x1 <= d;
      if (state == WAIT_Y_HI && hs) y1 <= d;
      if (state == C1 || state == C3) acc <= mo;
      if (state == C2) x2 <= mo;
      if (state == C4) y2 <= mo;
      if (state == C4) LED <= x2;
      else if (state == SHOW_X && hs) LED <= y2;
    end
  end
endmodule

// File: tb/tb_pico_mips.sv
// tb_pico_mips: vector table plus scoreboard of expected LED values for pico_mips.
module tb_pico_mips;
  import pico_mips_pkg::*;
`ifdef PICOMIPS_SYNC_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 5;
`endif
  typedef struct {
    logic [7:0] x, y, ex2, ey2;
  } vec_t;
  logic clk = 0, reset;
  logic [9:0] SW;
  logic [7:0] LED, last_led;
  logic [7:0] sb[$];
  int tests = 0, fails = 0;
  vec_t v[4];
  pico_mips dut (.clk(clk), .reset(reset), .SW(SW), .LED(LED));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input logic h, input logic [7:0] dt, input int n);
    SW = {1'b0, h, dt};
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [7:0] mdl(input logic [7:0] x, input logic [7:0] y, input bit second);
    int xi, yi, r;
    xi = int'($signed(x));
    yi = int'($signed(y));
    r = second ? -20 + ((-64 * xi) >>> 7) + ((96 * yi) >>> 7) : 20 + ((96 * xi) >>> 7) + ((64 * yi) >>> 7);
    return r[7:0];
  endfunction
  task automatic finish_pair(input string n);
    logic [7:0] e;
    chk({n, "_pre"}, LED, last_led);
    @(negedge clk);
    e = sb.pop_front();
    chk({n, "_x2"}, LED, e);
    drive(1, 8'h00, 4);
    e = sb.pop_front();
    chk({n, "_y2"}, LED, e);
    last_led = e;
    drive(0, 8'h00, 4);
    chk({n, "_hold"}, LED, last_led);
    chk({n, "_state"}, dut.state, WAIT_X_HI);
  endtask
  task automatic pair(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ex2,
                      input logic [7:0] ey2, input string n);
    sb.push_back(ex2);
    sb.push_back(ey2);
    drive(1, x, 4);
    drive(0, x, 4);
    drive(1, y, 4);
    drive(0, y, LAT - 1);
    finish_pair(n);
  endtask
  initial begin
    SW = '0;
    reset = 1;
    last_led = '0;
    drive(0, 8'h00, 3);
    reset = 0;
    chk("reset_led", LED, 8'h00);
    chk("reset_state", dut.state, WAIT_X_HI);
    v[0] = '{8'h08, 8'h10, 8'h22, 8'hF4};
    v[1] = '{8'h0A, 8'hF6, 8'h16, 8'hDF};
    v[2] = '{8'h7F, 8'h7F, 8'hB2, 8'h0B};
    v[3] = '{8'h80, 8'h80, 8'h74, 8'hCC};
    for (int i = 0; i < 4; i++) pair(v[i].x, v[i].y, v[i].ex2, v[i].ey2, $sformatf("v%0d", i));
    sb.push_back(mdl(8'h33, 8'hC5, 0));
    sb.push_back(mdl(8'h33, 8'hC5, 1));
    drive(1, 8'h33, 2);
    for (int i = 0; i < 8; i++) drive(1, 8'($urandom_range(0, 255)), 1);
    drive(0, 8'h00, 4);
    drive(1, 8'hC5, 4);
    drive(0, 8'h5A, LAT - 1);
    finish_pair("hold");
    drive(1, 8'h11, 4);
    drive(0, 8'h11, 4);
    drive(1, 8'h22, 4);
    drive(0, 8'h22, LAT - 3);
    chk("mid_in_c2", dut.state, C2);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_state", dut.state, WAIT_X_HI);
    chk("mid_rst_led", LED, 8'h00);
    reset = 0;
    last_led = '0;
    pair(8'hE7, 8'h42, mdl(8'hE7, 8'h42, 0), mdl(8'hE7, 8'h42, 1), "after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pico_mips.md
Name: pico_mips

Overview:
- Small handshake-driven affine-transform engine for the FPGA board top level.
- Reads two signed 8-bit operands x1 and y1 from slide switches using a switch handshake.
- Computes x2 = 0.75·x1 + 0.5·y1 + 20 and y2 = −0.5·x1 + 0.75·y1 − 20 in Q1.7 fixed point.
- Shows x2 and then y2 on the LEDs, stepped by the same handshake switch.

Parameters:
- W, 8: data width of operands, results and LED.
- A11, 96: x2 coefficient on x1 (signed Q1.7, 0.75).
- A12, 64: x2 coefficient on y1 (0.5).
- A21, −64: y2 coefficient on x1 (−0.5).
- A22, 96: y2 coefficient on y1 (0.75).
- B1, 20: x2 offset (signed integer).
- B2, −20: y2 offset (signed integer).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- SW  input  10  SW[7:0] signed data operand; SW[8] handshake; SW[9] ignored by this block (the board wrapper derives reset from it).
- LED  output  8  displayed result (two's complement).

Behaviour:
- Reset (synchronous, active-high): state=WAIT_X_HI; x1, y1, x2, y2, accumulator and LED all 0. Reset mid-operation aborts any computation the same way.
- SW is sampled directly, with no synchronizer unless the optional feature is enabled. The handshake level is read once per cycle.
- WAIT_X_HI: when SW[8]=1, latch x1=SW[7:0] and go to WAIT_X_LO.
- WAIT_X_LO: when SW[8]=0, go to WAIT_Y_HI.
- WAIT_Y_HI: when SW[8]=1, latch y1=SW[7:0] and go to WAIT_Y_LO.
- WAIT_Y_LO: when SW[8]=0, go to C1.
- A handshake held high for many cycles latches exactly once. SW[7:0] changes outside the latch cycle are ignored.
- Compute states use one shared multiply/scale unit, f(a,b) = bits [14:7] of the signed 16-bit product a·b (floor toward −∞):
  - C1: acc = B1 + f(A11,x1).
  - C2: x2 = acc + f(A12,y1).
  - C3: acc = B2 + f(A21,x1).
  - C4: y2 = acc + f(A22,y1); next state SHOW_X.
- All additions are 8-bit two's-complement with wrap-around; no saturation.
- SHOW_X: LED=x2, registered, valid the first cycle in SHOW_X. This is 5 cycles after SW[8] falls for y1. When SW[8]=1, go to SHOW_Y.
- SHOW_Y: LED=y2 from the next cycle. When SW[8]=0, go to WAIT_X_HI.
- LED holds y2 through the next input phase until the next SHOW_X.
- In WAIT/compute states LED keeps its last value; after reset it is 0.
- SW[8] toggling during C1–C4 is ignored.

Optional Feature:
- Macro: PICOMIPS_SYNC_EN.
- When defined, SW[8] passes through a two-flop synchronizer and SW[7:0] is registered once before use. All handshake decisions are delayed 2 cycles, so x2 appears 7 cycles after the y1 release.
- When undefined, SW is used combinationally as described above.

Decomposition:
- Package pico_mips_pkg holds:
  - state enum (WAIT_X_HI, WAIT_X_LO, WAIT_Y_HI, WAIT_Y_LO, C1..C4, SHOW_X, SHOW_Y);
  - default coefficient and offset constants;
  - W.
- One sub-module, pico_mips_mac: combinational signed 8×8 multiply, bits [14:7] select, add to an 8-bit addend. It is instantiated once in the top level, with its inputs muxed by state.

Test Plan:
- Reset, then x1=8, y1=16 via handshake -> 5 cycles after release LED=0x22 (34). SW[8]=1 -> LED=0xF4 (−12). SW[8]=0 -> back to WAIT_X_HI with LED still 0xF4.
- Second loop: x1=10, y1=0xF6 (−10) -> LED=0x16 (22). Then SW[8]=1 -> LED=0xDF (−33), which confirms floor truncation.
- Overflow wrap: x1=127, y1=127 -> x2=0xB2, y2=0x0B. Also x1=0x80, y1=0x80 -> x2=0x74, y2=0xCC.
- Handshake held high for 10 cycles while SW[7:0] changes -> only the value present on the first high cycle is latched.
- Reset asserted during C2 -> next cycle state=WAIT_X_HI and LED=0. A following full handshake sequence gives correct results.
- With PICOMIPS_SYNC_EN defined: repeat the first scenario -> identical values, with x2 appearing 7 cycles after the y1 release.
